// File: rtl/qif_pkg.sv
// Shared types, defaults and saturation helper for the QIF neuron array.
package qif_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_V_PEAK  = 100;
    localparam int DEF_V_RESET = -20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } qif_state_e;

    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] x,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] r;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        r  = x;
        if (x > hi) r = hi;
        else if (x < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/qif_update_core.sv
// Combinational QIF membrane update for one channel.
// Refractory handling is present only when QIF_REFRAC_EN is defined.
module qif_update_core
    import qif_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int SHIFT = 4,
    parameter logic signed [W-1:0] V_PEAK = W'(DEF_V_PEAK),
    parameter logic signed [W-1:0] V_RESET = W'(DEF_V_RESET)
`ifdef QIF_REFRAC_EN
    ,
    parameter int REFRAC = 3,
    parameter int RW = $clog2(REFRAC + 1)
`endif
) (
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] i,
`ifdef QIF_REFRAC_EN
    input  logic [RW-1:0]       rc,
    output logic [RW-1:0]       rc_next,
`endif
    output logic signed [W-1:0] v_next,
    output logic                spike
);

    logic signed [2*W-1:0] prod;
    logic [2*W-1:0]        sq;
    logic signed [2*W+1:0] sum;
    logic signed [31:0]    sat;
    logic signed [W-1:0]   vn;

    always_comb begin
        prod = v * v;
        sq   = unsigned'(prod) >> SHIFT;
        sum  = (2*W+2)'(v) + $signed({2'b00, sq}) + (2*W+2)'(i);
        sat  = sat_signed(32'(sum), W);
        vn   = W'(sat);
`ifdef QIF_REFRAC_EN
        if (rc != '0) begin
            v_next  = V_RESET;
            spike   = 1'b0;
            rc_next = rc - RW'(1);
        end else if (vn >= V_PEAK) begin
            v_next  = V_RESET;
            spike   = 1'b1;
            rc_next = RW'(REFRAC);
        end else begin
            v_next  = vn;
            spike   = 1'b0;
            rc_next = '0;
        end
`else
        if (vn >= V_PEAK) begin
            v_next = V_RESET;
            spike  = 1'b1;
        end else begin
            v_next = vn;
            spike  = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/qif_neuron_array.sv
// N_CH-channel QIF neuron array sharing one update core across channels.
// Optional refractory period enabled by defining QIF_REFRAC_EN.
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int W = DEF_W,
    parameter int SHIFT = 4,
    parameter logic signed [W-1:0] V_PEAK = W'(DEF_V_PEAK),
    parameter logic signed [W-1:0] V_RESET = W'(DEF_V_RESET),
    parameter int REFRAC = 3,
    localparam int AW = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cur_we,
    input  logic [AW-1:0]       cur_addr,
    input  logic signed [W-1:0] cur_data,
    input  logic                step_valid,
    output logic                step_ready,
    output logic                busy,
    output logic                spk_valid,
    output logic [N_CH-1:0]     spikes,
    input  logic [AW-1:0]       mon_addr,
    output logic signed [W-1:0] mon_v
);

    qif_state_e          state;
    logic [AW-1:0]       idx;
    logic signed [W-1:0] v_q [N_CH];
    logic signed [W-1:0] i_q [N_CH];
    logic [N_CH-1:0]     shadow;
    logic [N_CH-1:0]     shadow_nx;
    logic signed [W-1:0] v_nx;
    logic                spk;
    logic                last;

`ifdef QIF_REFRAC_EN
    localparam int RW = $clog2(REFRAC + 1);
    logic [RW-1:0] rc_q [N_CH];
    logic [RW-1:0] rc_nx;

    qif_update_core #(
        .W(W), .SHIFT(SHIFT), .V_PEAK(V_PEAK),
        .V_RESET(V_RESET), .REFRAC(REFRAC), .RW(RW)
    ) u_core (
        .v(v_q[idx]), .i(i_q[idx]),
        .rc(rc_q[idx]), .rc_next(rc_nx),
        .v_next(v_nx), .spike(spk)
    );
`else
    logic unused_refrac;
    assign unused_refrac = (REFRAC != 0);

    qif_update_core #(
        .W(W), .SHIFT(SHIFT), .V_PEAK(V_PEAK), .V_RESET(V_RESET)
    ) u_core (
        .v(v_q[idx]), .i(i_q[idx]),
        .v_next(v_nx), .spike(spk)
    );
`endif

    assign last       = (idx == AW'(N_CH - 1));
    assign step_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign spk_valid  = (state == DONE);

    always_comb begin
        shadow_nx      = shadow;
        shadow_nx[idx] = spk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            shadow <= '0;
            spikes <= '0;
            mon_v  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                v_q[k] <= V_RESET;
                i_q[k] <= '0;
`ifdef QIF_REFRAC_EN
                rc_q[k] <= '0;
`endif
            end
        end else begin
            mon_v <= v_q[mon_addr];
            // Core has already read i_q[idx], so a same-cycle write lands next step
            if (cur_we) i_q[cur_addr] <= cur_data;
            unique case (1'b1)
                (state == IDLE): begin
                    if (step_valid) begin
                        state <= SWEEP;
                        idx   <= '0;
                    end
                end
                (state == SWEEP): begin
                    v_q[idx] <= v_nx;
`ifdef QIF_REFRAC_EN
                    rc_q[idx] <= rc_nx;
`endif
                    shadow <= shadow_nx;
                    if (last) begin
                        state  <= DONE;
                        spikes <= shadow_nx;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qif_neuron_array.sv
// Self-checking bench for qif_neuron_array: tables, corner sequences, random vs model.
module tb_qif_neuron_array;

    localparam int N_CH    = 8;
    localparam int W       = 8;
    localparam int SHIFT   = 4;
    localparam int V_PEAK  = 100;
    localparam int V_RESET = -20;
    localparam int REFRAC  = 3;

    logic              clk;
    logic              rst;
    logic              cur_we;
    logic [2:0]        cur_addr;
    logic signed [7:0] cur_data;
    logic              step_valid;
    logic              step_ready;
    logic              busy;
    logic              spk_valid;
    logic [N_CH-1:0]   spikes;
    logic [2:0]        mon_addr;
    logic signed [7:0] mon_v;

    int total = 0;
    int bad   = 0;

    int mv [N_CH];
    int mi [N_CH];
    int mr [N_CH];

    typedef struct {
        int ch;
        int cur;
        int exp_v;
        int exp_spk;
    } vec_t;

    qif_neuron_array dut (
        .clk(clk), .rst(rst),
        .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
        .step_valid(step_valid), .step_ready(step_ready),
        .busy(busy), .spk_valid(spk_valid), .spikes(spikes),
        .mon_addr(mon_addr), .mon_v(mon_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N_CH; k++) begin
            mv[k] = V_RESET;
            mi[k] = 0;
            mr[k] = 0;
        end
    endfunction

    // Plain-integer QIF rule applied to every channel for one timestep
    function automatic logic [N_CH-1:0] model_step();
        logic [N_CH-1:0] s;
        int sum;
        s = '0;
        for (int k = 0; k < N_CH; k++) begin
`ifdef QIF_REFRAC_EN
            if (mr[k] > 0) begin
                mv[k] = V_RESET;
                mr[k] = mr[k] - 1;
                continue;
            end
`endif
            sum = mv[k] + ((mv[k] * mv[k]) >> SHIFT) + mi[k];
            if (sum > 127) sum = 127;
            if (sum < -128) sum = -128;
            if (sum >= V_PEAK) begin
                s[k]  = 1'b1;
                mv[k] = V_RESET;
                mr[k] = REFRAC;
            end else begin
                mv[k] = sum;
            end
        end
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wr_cur(input int ch, input int val);
        @(negedge clk);
        cur_we   = 1'b1;
        cur_addr = 3'(ch);
        cur_data = 8'(val);
        @(negedge clk);
        cur_we = 1'b0;
        mi[ch] = val;
    endtask

    task automatic read_v(input int ch, output int v);
        @(negedge clk);
        mon_addr = 3'(ch);
        @(negedge clk);
        v = int'(mon_v);
    endtask

    task automatic check_all_v(input string tag);
        int v;
        for (int k = 0; k < N_CH; k++) begin
            read_v(k, v);
            chk($sformatf("%s_v%0d", tag, k), v, mv[k]);
        end
    endtask

    // wr_at > 0: write cur register during sweep cycle wr_at after acceptance
    task automatic do_step(input int wr_at, input int wr_ch, input int wr_val,
                           output logic [N_CH-1:0] spk);
        int cnt;
        bit got;
        bit stable;
        logic [N_CH-1:0] sp0;
        @(negedge clk);
        step_valid = 1'b1;
        sp0 = spikes;
        @(posedge clk);
        #1 step_valid = 1'b0;
        cnt = 0;
        got = 1'b0;
        stable = 1'b1;
        while (!got && cnt < 40) begin
            @(negedge clk);
            cnt++;
            cur_we = 1'b0;
            if (cnt == wr_at) begin
                cur_we   = 1'b1;
                cur_addr = 3'(wr_ch);
                cur_data = 8'(wr_val);
            end
            if (cnt == 1) chk("busy_in_sweep", int'(busy), 1);
            if (spk_valid) got = 1'b1;
            else if (spikes != sp0) stable = 1'b0;
        end
        cur_we = 1'b0;
        chk("latency", cnt, N_CH + 1);
        chk("spikes_stable", int'(stable), 1);
        spk = spikes;
        @(negedge clk);
        chk("spk_valid_pulse", int'(spk_valid), 0);
        chk("ready_after", int'(step_ready), 1);
    endtask

    vec_t tbl [N_CH];
`ifdef QIF_REFRAC_EN
    localparam int NS = 7;
    int e1v [NS] = '{45, -20, -20, -20, -20, 45, -20};
    int e1s [NS] = '{0, 1, 0, 0, 0, 0, 1};
`else
    localparam int NS = 4;
    int e1v [NS] = '{45, -20, 45, -20};
    int e1s [NS] = '{0, 1, 0, 1};
`endif
    int e0v [2] = '{5, 6};

    initial begin
        logic [N_CH-1:0] spk;
        logic [N_CH-1:0] exp_s;
        int v;
        int pulses;
        int wa, wch, wval;

        rst = 1'b1;
        cur_we = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        step_valid = 1'b0;
        mon_addr = '0;
        model_reset();
        do_reset();

        chk("reset_spikes", int'(spikes), 0);
        chk("reset_ready", int'(step_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_spk_valid", int'(spk_valid), 0);
        for (int k = 0; k < N_CH; k++) begin
            read_v(k, v);
            chk($sformatf("reset_v%0d", k), v, -20);
        end

        // One step from V_RESET, threshold and saturation boundaries
        tbl[0] = '{0,    0,    5, 0};
        tbl[1] = '{1,   94,   99, 0};
        tbl[2] = '{2,   95,  -20, 1};
        tbl[3] = '{3,  127,  -20, 1};
        tbl[4] = '{4, -128, -123, 0};
        tbl[5] = '{5,  -30,  -25, 0};
        tbl[6] = '{6,   74,   79, 0};
        tbl[7] = '{7,   40,   45, 0};
        for (int n = 0; n < N_CH; n++) wr_cur(tbl[n].ch, tbl[n].cur);
        do_step(-1, 0, 0, spk);
        for (int n = 0; n < N_CH; n++) begin
            chk($sformatf("tbl_spk%0d", n), int'(spk[tbl[n].ch]), tbl[n].exp_spk);
            read_v(tbl[n].ch, v);
            chk($sformatf("tbl_v%0d", n), v, tbl[n].exp_v);
        end

        // Integration chain on ch0 (I=0) and ch1 (I=40)
        do_reset();
        wr_cur(1, 40);
        for (int s = 0; s < NS; s++) begin
            do_step(-1, 0, 0, spk);
            exp_s = model_step();
            chk($sformatf("chain_spk1_s%0d", s), int'(spk[1]), e1s[s]);
            read_v(1, v);
            chk($sformatf("chain_v1_s%0d", s), v, e1v[s]);
            if (s < 2) begin
                read_v(0, v);
                chk($sformatf("chain_v0_s%0d", s), v, e0v[s]);
            end
        end

        // Current write in the very cycle channel 3 is swept
        do_reset();
        do_step(4, 3, 40, spk);
        read_v(3, v);
        chk("rbw_old_i", v, 5);
        do_step(-1, 0, 0, spk);
        read_v(3, v);
        chk("rbw_new_i", v, 46);

        // Reset asserted mid-sweep
        wr_cur(2, 50);
        @(negedge clk);
        step_valid = 1'b1;
        @(posedge clk);
        #1 step_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", int'(step_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (spk_valid) pulses++;
        end
        chk("midrst_no_pulse", pulses, 0);
        model_reset();
        check_all_v("midrst");
        do_step(-1, 0, 0, spk);
        exp_s = model_step();
        chk("midrst_spikes", int'(spk), int'(exp_s));
        check_all_v("midrst_after");

        // Randomized steps against the behavioural model
        do_reset();
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) begin
                wch = int'($urandom_range(0, N_CH - 1));
                wval = int'($urandom_range(0, 100)) - 50;
                if ($urandom_range(0, 7) == 0) wval = int'($urandom_range(0, 255)) - 128;
                wr_cur(wch, wval);
            end
            wa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N_CH)) : -1;
            wch = int'($urandom_range(0, N_CH - 1));
            wval = int'($urandom_range(0, 80)) - 40;
            do_step(wa, wch, wval, spk);
            if (wa > 0 && wch >= wa) mi[wch] = wval;
            exp_s = model_step();
            if (wa > 0 && wch < wa) mi[wch] = wval;
            chk($sformatf("rnd_spikes_%0d", it), int'(spk), int'(exp_s));
            check_all_v($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
